// File: rtl/arm_regfile_sb.sv
// arm_regfile_sb: 16 x N ARM register bank (R0-R14 stored, R15 = pc_plus8)
// with a load scoreboard (per-register busy bits, outstanding-load counter)
// and a combinational decode stall.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : regs_flat forwards same-cycle write data (load over ALU,
//               R15 excluded); stall ignores busy bits cleared this cycle.
//   undefined : no forwarding; consumers see writes one cycle later.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   pc_plus8              value shown in the R15 slot
//   alu_we/wa/wd          execute write port
//   ld_we/wa/wd           load write-back port (wins over ALU on same address)
//   ld_issue, ld_dest     load issued by decode
//   rd_sel_*/rd_vld_*     operand selects and their valid flags
//   regs_flat             R0 at [N-1:0] ... R15 at [16N-1:15N]
//   busy                  pending-load bits, bit 15 always 0
//   pend_cnt              outstanding loads
//   stall                 decode must hold this cycle (combinational)
module arm_regfile_sb #(
  parameter int unsigned N        = 32,
  parameter int unsigned MAX_PEND = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N-1:0]                    pc_plus8,
  input  logic                            alu_we,
  input  logic [3:0]                      alu_wa,
  input  logic [N-1:0]                    alu_wd,
  input  logic                            ld_we,
  input  logic [3:0]                      ld_wa,
  input  logic [N-1:0]                    ld_wd,
  input  logic                            ld_issue,
  input  logic [3:0]                      ld_dest,
  input  logic [3:0]                      rd_sel_a,
  input  logic [3:0]                      rd_sel_b,
  input  logic [3:0]                      rd_sel_c,
  input  logic                            rd_vld_a,
  input  logic                            rd_vld_b,
  input  logic                            rd_vld_c,
  output logic [16*N-1:0]                 regs_flat,
  output logic [15:0]                     busy,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
  output logic                            stall
);

  localparam int unsigned PW = $clog2(MAX_PEND + 1);

  logic [N-1:0]  regs_q [15];
  logic [N-1:0]  regs_d [15];
  logic [14:0]   busy_q, busy_d;
  logic [PW-1:0] pend_cnt_q, pend_cnt_d;

  logic [15:0]   busy_ext;
  logic [15:0]   clr_mask;
  logic [15:0]   busy_eff;
  logic          rd_haz, waw_haz, full_haz, accept, dec;

  assign busy_ext = {1'b0, busy_q};
  assign busy     = busy_ext;
  assign pend_cnt = pend_cnt_q;

  // Scoreboard hazard detection and issue acceptance
  always_comb begin
    clr_mask = '0;
    if (ld_we && busy_ext[ld_wa]) clr_mask[ld_wa] = 1'b1;
`ifdef REGFILE_BYPASS_EN
    busy_eff = busy_ext & ~clr_mask;
`else
    busy_eff = busy_ext;
`endif
    rd_haz   = (rd_vld_a && busy_eff[rd_sel_a]) ||
               (rd_vld_b && busy_eff[rd_sel_b]) ||
               (rd_vld_c && busy_eff[rd_sel_c]);
    waw_haz  = ld_issue && busy_eff[ld_dest];
    full_haz = ld_issue && (pend_cnt_q == PW'(MAX_PEND));
    stall    = rd_haz || waw_haz || full_haz;
    accept   = ld_issue && !stall && (ld_dest != 4'd15);
    // Counter never goes below zero even if a stale write-back arrives
    dec      = (|clr_mask) && (pend_cnt_q != '0);
  end

  // Next-state: register writes, busy update (set beats clear), counter
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    pend_cnt_d = pend_cnt_q + PW'(accept) - PW'(dec);
    for (int i = 0; i < 15; i++) begin
      if (alu_we && alu_wa == 4'(i)) regs_d[i] = alu_wd;
      if (ld_we && ld_wa == 4'(i))   regs_d[i] = ld_wd;
      if (clr_mask[i])               busy_d[i] = 1'b0;
      if (accept && ld_dest == 4'(i)) busy_d[i] = 1'b1;
    end
  end

  // Flat register view; R15 slot is always the external PC+8
  always_comb begin
    for (int i = 0; i < 15; i++) begin
`ifdef REGFILE_BYPASS_EN
      if (ld_we && ld_wa == 4'(i))        regs_flat[i*N +: N] = ld_wd;
      else if (alu_we && alu_wa == 4'(i)) regs_flat[i*N +: N] = alu_wd;
      else                                regs_flat[i*N +: N] = regs_q[i];
`else
      regs_flat[i*N +: N] = regs_q[i];
`endif
    end
    regs_flat[15*N +: N] = pc_plus8;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// Directed, table-driven bench for arm_regfile_sb (N=32, MAX_PEND=4).
// Each record is one clock cycle: inputs are applied after the edge, outputs
// are checked mid-cycle, then the clock advances.
module tb_arm_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] PC8 = 32'h0000_0108;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   pc_plus8;
  logic          alu_we, ld_we, ld_issue;
  logic [3:0]    alu_wa, ld_wa, ld_dest;
  logic [31:0]   alu_wd, ld_wd;
  logic [3:0]    rd_sel_a, rd_sel_b, rd_sel_c;
  logic          rd_vld_a, rd_vld_b, rd_vld_c;
  logic [511:0]  regs_flat;
  logic [15:0]   busy;
  logic [2:0]    pend_cnt;
  logic          stall;

  always #5 clk = ~clk;

  arm_regfile_sb #(.N(32), .MAX_PEND(4)) dut (
    .clk(clk), .reset_n(reset_n), .pc_plus8(pc_plus8),
    .alu_we(alu_we), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_we(ld_we), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .ld_issue(ld_issue), .ld_dest(ld_dest),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_sel_c(rd_sel_c),
    .rd_vld_a(rd_vld_a), .rd_vld_b(rd_vld_b), .rd_vld_c(rd_vld_c),
    .regs_flat(regs_flat), .busy(busy), .pend_cnt(pend_cnt), .stall(stall)
  );

  typedef struct {
    logic        rst_n;
    logic        awe;  logic [3:0] awa; logic [31:0] awd;
    logic        lwe;  logic [3:0] lwa; logic [31:0] lwd;
    logic        iss;  logic [3:0] dst;
    logic [4:0]  ra;   logic [4:0] rb;  logic [4:0]  rc;   // {vld, sel}
    int          chk;  logic [31:0] exp_reg;
    logic        exp_stall; logic [15:0] exp_busy; logic [2:0] exp_pend;
  } vec_t;

  vec_t vq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic rst_n,
                     input logic awe, input logic [3:0] awa, input logic [31:0] awd,
                     input logic lwe, input logic [3:0] lwa, input logic [31:0] lwd,
                     input logic iss, input logic [3:0] dst,
                     input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc,
                     input int chk, input logic [31:0] exp_reg,
                     input logic exp_stall, input logic [15:0] exp_busy,
                     input logic [2:0] exp_pend);
    vec_t v;
    v.rst_n = rst_n; v.awe = awe; v.awa = awa; v.awd = awd;
    v.lwe = lwe; v.lwa = lwa; v.lwd = lwd; v.iss = iss; v.dst = dst;
    v.ra = ra; v.rb = rb; v.rc = rc; v.chk = chk; v.exp_reg = exp_reg;
    v.exp_stall = exp_stall; v.exp_busy = exp_busy; v.exp_pend = exp_pend;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset_n  = v.rst_n;
    alu_we   = v.awe; alu_wa = v.awa; alu_wd = v.awd;
    ld_we    = v.lwe; ld_wa  = v.lwa; ld_wd  = v.lwd;
    ld_issue = v.iss; ld_dest = v.dst;
    {rd_vld_a, rd_sel_a} = v.ra;
    {rd_vld_b, rd_sel_b} = v.rb;
    {rd_vld_c, rd_sel_c} = v.rc;
  endtask

  initial begin
    logic [31:0] slot;
    pc_plus8 = PC8;
    drive('{rst_n:1'b0, awe:1'b0, awa:4'd0, awd:32'd0, lwe:1'b0, lwa:4'd0,
            lwd:32'd0, iss:1'b0, dst:4'd0, ra:5'd0, rb:5'd0, rc:5'd0, chk:0,
            exp_reg:32'd0, exp_stall:1'b0, exp_busy:16'd0, exp_pend:3'd0});
    repeat (2) @(posedge clk);
    #1;

    //   rst awe awa awd            lwe lwa lwd            iss dst  ra     rb     rc     chk exp_reg                          stl busy      pend
    // reset state and R15 slot
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     0,  32'h0,                           0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     15, PC8,                             0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     14, 32'h0,                           0, 16'h0000, 0);
    // ALU write, R15 write ignored
    add(1, 1, 3, 32'hDEADBEEF,  0, 0, 0,             0, 0,  0,     0,     0,     3,  BYP ? 32'hDEADBEEF : 32'h0,      0, 16'h0000, 0);
    add(1, 1, 15, 32'h1234,     0, 0, 0,             0, 0,  0,     0,     0,     15, PC8,                             0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     3,  32'hDEADBEEF,                    0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     15, PC8,                             0, 16'h0000, 0);
    // load to R5, dependent read on ports a/b/c
    add(1, 0, 0, 0,             0, 0, 0,             1, 5,  0,     0,     0,     5,  32'h0,                           0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  5'h15, 0,     0,     5,  32'h0,                           1, 16'h0020, 1);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  5'h05, 5'h15, 0,     5,  32'h0,                           1, 16'h0020, 1);
    add(1, 0, 0, 0,             1, 5, 32'hCAFE0001,  0, 0,  0,     0,     5'h15, 5,  BYP ? 32'hCAFE0001 : 32'h0,      !BYP, 16'h0020, 1);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     5'h15, 5,  32'hCAFE0001,                    0, 16'h0000, 0);
    // same-address ALU and load write
    add(1, 1, 2, 32'h11,        1, 2, 32'h22,        0, 0,  0,     0,     0,     2,  BYP ? 32'h22 : 32'h0,            0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     2,  32'h22,                          0, 16'h0000, 0);
    // fill the queue, fifth load blocked until one write-back
    add(1, 0, 0, 0,             0, 0, 0,             1, 1,  0,     0,     0,     0,  32'h0,                           0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             1, 2,  0,     0,     0,     0,  32'h0,                           0, 16'h0002, 1);
    add(1, 0, 0, 0,             0, 0, 0,             1, 3,  5'h01, 0,     0,     0,  32'h0,                           0, 16'h0006, 2);
    add(1, 0, 0, 0,             0, 0, 0,             1, 4,  0,     0,     0,     0,  32'h0,                           0, 16'h000E, 3);
    add(1, 0, 0, 0,             0, 0, 0,             1, 6,  0,     0,     0,     6,  32'h0,                           1, 16'h001E, 4);
    add(1, 0, 0, 0,             1, 1, 32'h77,        1, 6,  0,     0,     0,     1,  BYP ? 32'h77 : 32'h0,            1, 16'h001E, 4);
    add(1, 0, 0, 0,             0, 0, 0,             1, 6,  0,     0,     0,     1,  32'h77,                          0, 16'h001C, 3);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     1,  32'h77,                          0, 16'h005C, 4);
    // WAW hazard, and write-back with re-issue to the same register
    add(1, 0, 0, 0,             1, 4, 32'h44,        0, 0,  0,     0,     0,     0,  32'h0,                           0, 16'h005C, 4);
    add(1, 0, 0, 0,             0, 0, 0,             1, 3,  0,     0,     0,     4,  32'h44,                          1, 16'h004C, 3);
    add(1, 0, 0, 0,             1, 3, 32'h33,        1, 3,  0,     0,     0,     4,  32'h44,                          !BYP, 16'h004C, 3);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     3,  32'h33,                          0, BYP ? 16'h004C : 16'h0044, BYP ? 3'd3 : 3'd2);
    // load to R15 is never accepted; reading R15 never stalls
    add(1, 0, 0, 0,             0, 0, 0,             1, 15, 0,     0,     0,     15, PC8,                             0, BYP ? 16'h004C : 16'h0044, BYP ? 3'd3 : 3'd2);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  5'h1F, 0,     0,     15, PC8,                             0, BYP ? 16'h004C : 16'h0044, BYP ? 3'd3 : 3'd2);
    // reset with loads pending and a simultaneous issue
    add(0, 0, 0, 0,             0, 0, 0,             1, 7,  0,     0,     0,     3,  32'h33,                          0, BYP ? 16'h004C : 16'h0044, BYP ? 3'd3 : 3'd2);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     3,  32'h0,                           0, 16'h0000, 0);
    add(1, 0, 0, 0,             0, 0, 0,             0, 0,  0,     0,     0,     15, PC8,                             0, 16'h0000, 0);

    foreach (vq[i]) begin
      drive(vq[i]);
      #4;
      slot = regs_flat[vq[i].chk*32 +: 32];
      check("stall", i, 32'(stall), 32'(vq[i].exp_stall));
      check("busy", i, 32'(busy), 32'(vq[i].exp_busy));
      check("pend_cnt", i, 32'(pend_cnt), 32'(vq[i].exp_pend));
      check($sformatf("reg%0d", vq[i].chk), i, slot, vq[i].exp_reg);
      @(posedge clk);
      #1;
    end

    // Hand sequence: ALU write to a busy register keeps it busy, then
    // write-back to a non-busy register leaves the counter at zero.
    reset_n = 1'b1; alu_we = 1'b0; ld_we = 1'b0;
    ld_issue = 1'b1; ld_dest = 4'd8;
    rd_vld_a = 1'b0; rd_vld_b = 1'b0; rd_vld_c = 1'b0;
    @(posedge clk); #1;
    ld_issue = 1'b0;
    alu_we = 1'b1; alu_wa = 4'd8; alu_wd = 32'h99;
    @(posedge clk); #1;
    alu_we = 1'b0;
    #4;
    check("alu_busy_kept", 100, 32'(busy), 32'h0100);
    check("alu_busy_data", 100, regs_flat[8*32 +: 32], 32'h99);
    check("alu_busy_pend", 100, 32'(pend_cnt), 32'd1);
    @(posedge clk); #1;
    ld_we = 1'b1; ld_wa = 4'd8; ld_wd = 32'hAA;
    @(posedge clk); #1;
    ld_wa = 4'd9; ld_wd = 32'hBB;
    @(posedge clk); #1;
    ld_we = 1'b0;
    #4;
    check("wb_r8", 101, regs_flat[8*32 +: 32], 32'hAA);
    check("wb_r9", 101, regs_flat[9*32 +: 32], 32'hBB);
    check("pend_floor", 101, 32'(pend_cnt), 32'd0);
    check("busy_clear", 101, 32'(busy), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
